parking_lane_sensor: RTL and testbench

Direction-decoding front end for one parking lane. It watches two optical beams across the lane: outer (street side) and inner (lot side). It decodes the order in which a vehicle breaks and clears them, and emits exactly one single-cycle `entry_pulse` or `exit_pulse` per completed passage. These pulses feed the lot space counter. The block also drives the lane barrier and flags aborted or stuck sequences.

---
 rtl/parking_lane_sensor_pkg.sv | 39 +++
 rtl/parking_lane_sensor_if.sv | 33 +++
 rtl/parking_lane_sensor_beam_filter.sv | 49 ++++
 rtl/parking_lane_sensor.sv | 177 +++++++++++++++++
 tb/tb_parking_lane_sensor.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/parking_lane_sensor_pkg.sv
// Shared types and defaults for the parking lane direction decoder.
// The lane state enum and beam-pattern encoding are used by the top and the bench.
package parking_pkg;

    localparam int DEF_FILTER_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENT1       = 3'd1,
        ENT2       = 3'd2,
        ENT3       = 3'd3,
        EXT1       = 3'd4,
        EXT2       = 3'd5,
        EXT3       = 3'd6,
        WAIT_CLEAR = 3'd7
    } lane_state_t;

    // Filtered beam pair, outer beam in the MSB
    typedef enum logic [1:0] {
        BEAMS_NONE = 2'b00,
        BEAMS_I    = 2'b01,
        BEAMS_O    = 2'b10,
        BEAMS_OI   = 2'b11
    } beam_pat_t;

    function automatic logic is_timed(input lane_state_t s);
        return (s != IDLE) && (s != WAIT_CLEAR);
    endfunction

    function automatic logic is_entry(input lane_state_t s);
        return (s == ENT1) || (s == ENT2) || (s == ENT3);
    endfunction

    function automatic logic is_exit(input lane_state_t s);
        return (s == EXT1) || (s == EXT2) || (s == EXT3);
    endfunction

endpackage

// File: rtl/parking_lane_sensor_if.sv
// Lane-side signal bundle: beam and space inputs in, pulses and barrier/fault out.
// master drives the beams (sensor side / bench), slave is the decoder.
interface parking_lane_sensor_if;

    logic beam_outer;
    logic beam_inner;
    logic space_avail;
    logic entry_pulse;
    logic exit_pulse;
    logic gate_open;
    logic fault;

    modport master (
        output beam_outer,
        output beam_inner,
        output space_avail,
        input  entry_pulse,
        input  exit_pulse,
        input  gate_open,
        input  fault
    );

    modport slave (
        input  beam_outer,
        input  beam_inner,
        input  space_avail,
        output entry_pulse,
        output exit_pulse,
        output gate_open,
        output fault
    );

endinterface

// File: rtl/parking_lane_sensor_beam_filter.sv
// Two-flop synchronizer followed by a stability counter; the filtered level
// only moves after FILTER_CYCLES consecutive samples disagree with it.
module beam_filter
    import parking_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_beam,
    output logic o_level
);

    localparam int             CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_beam;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample matching the current level restarts the run, so short pulses die here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/parking_lane_sensor.sv
// Lane direction decoder: filters both beams, tracks the break/clear order and
// emits one entry or exit pulse per completed passage, plus barrier and fault.
module parking_lane_sensor
    import parking_pkg::*;
#(
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                  clk,
    input logic                  reset_n,
    parking_lane_sensor_if.slave lane
);

    localparam int            DW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    w_beam_raw;
    logic [1:0]    w_beam_filt;
    beam_pat_t     w_pat;

    lane_state_t   r_state;
    lane_state_t   w_next;
    logic [DW-1:0] r_dwell;
    logic          r_space_ok;
    logic          r_entry_pulse;
    logic          r_exit_pulse;
    logic          r_gate_open;
    logic          r_fault;

    logic          w_space_ok_next;
    logic          w_entry_done;
    logic          w_exit_done;
    logic          w_gate_next;
    logic          w_fault_next;
    logic          w_timeout;

    assign w_beam_raw = {lane.beam_outer, lane.beam_inner};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            beam_filter #(
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_filt (
                .clk     (clk),
                .reset_n (reset_n),
                .i_beam  (w_beam_raw[gi]),
                .o_level (w_beam_filt[gi])
            );
        end
    endgenerate

    assign w_pat     = beam_pat_t'(w_beam_filt);
    assign w_timeout = is_timed(r_state) && (r_dwell == DWELL_MAX);

    always_comb begin
        w_next          = r_state;
        w_space_ok_next = r_space_ok;
        w_entry_done    = 1'b0;
        w_exit_done     = 1'b0;
        w_gate_next     = 1'b0;
        w_fault_next    = 1'b0;

        case (r_state)
            IDLE: begin
                case (w_pat)
                    BEAMS_O:  w_next = ENT1;
                    BEAMS_I:  w_next = EXT1;
                    BEAMS_OI: w_next = WAIT_CLEAR;
                    default:  w_next = IDLE;
                endcase
            end
            ENT1: begin
                case (w_pat)
                    BEAMS_OI:   w_next = ENT2;
                    BEAMS_NONE: w_next = IDLE;
                    BEAMS_I:    w_next = WAIT_CLEAR;
                    default:    w_next = ENT1;
                endcase
            end
            ENT2: begin
                case (w_pat)
                    BEAMS_I:    w_next = ENT3;
                    BEAMS_O:    w_next = ENT1;
                    BEAMS_NONE: w_next = WAIT_CLEAR;
                    default:    w_next = ENT2;
                endcase
            end
            ENT3: begin
                case (w_pat)
                    BEAMS_NONE: w_next = IDLE;
                    BEAMS_OI:   w_next = ENT2;
                    BEAMS_O:    w_next = WAIT_CLEAR;
                    default:    w_next = ENT3;
                endcase
            end
            EXT1: begin
                case (w_pat)
                    BEAMS_OI:   w_next = EXT2;
                    BEAMS_NONE: w_next = IDLE;
                    BEAMS_O:    w_next = WAIT_CLEAR;
                    default:    w_next = EXT1;
                endcase
            end
            EXT2: begin
                case (w_pat)
                    BEAMS_O:    w_next = EXT3;
                    BEAMS_I:    w_next = EXT1;
                    BEAMS_NONE: w_next = WAIT_CLEAR;
                    default:    w_next = EXT2;
                endcase
            end
            EXT3: begin
                case (w_pat)
                    BEAMS_NONE: w_next = IDLE;
                    BEAMS_OI:   w_next = EXT2;
                    BEAMS_I:    w_next = WAIT_CLEAR;
                    default:    w_next = EXT3;
                endcase
            end
            WAIT_CLEAR: begin
                if (w_pat == BEAMS_NONE) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase

        // A stuck passage overrides whatever the beams would have done this cycle
        if (w_timeout) w_next = WAIT_CLEAR;

        if (r_state == IDLE && w_next == ENT1) w_space_ok_next = lane.space_avail;

        w_entry_done = (r_state == ENT3) && (w_next == IDLE);
        w_exit_done  = (r_state == EXT3) && (w_next == IDLE);
        w_gate_next  = is_exit(w_next) || (is_entry(w_next) && w_space_ok_next);
        w_fault_next = (w_next == WAIT_CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_space_ok <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_space_ok <= w_space_ok_next;
        end
    end

    // Dwell only accumulates while a passage sits in one decoding state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if (!is_timed(r_state) || (w_next != r_state)) begin
            r_dwell <= '0;
        end else if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entry_pulse <= 1'b0;
            r_exit_pulse  <= 1'b0;
            r_gate_open   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_entry_pulse <= w_entry_done;
            r_exit_pulse  <= w_exit_done;
            r_gate_open   <= w_gate_next;
            r_fault       <= w_fault_next;
        end
    end

    assign lane.entry_pulse = r_entry_pulse;
    assign lane.exit_pulse  = r_exit_pulse;
    assign lane.gate_open   = r_gate_open;
    assign lane.fault       = r_fault;

endmodule

// File: tb/tb_parking_lane_sensor.sv
// Directed bench for the lane decoder: entry, exit, back-out, glitch, full lot,
// illegal pattern, timeout and mid-passage reset, each with hand-derived results.
module tb_parking_lane_sensor;
    import parking_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    parking_lane_sensor_if lane ();

    parking_lane_sensor #(
        .FILTER_CYCLES  (4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lane    (lane)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Running totals observed on the falling edge; scenarios work with deltas
    int n_entry = 0;
    int n_exit  = 0;
    int n_gate  = 0;
    int n_both  = 0;
    int n_busy  = 0;

    always @(negedge clk) begin
        if (lane.entry_pulse === 1'b1) n_entry++;
        if (lane.exit_pulse === 1'b1)  n_exit++;
        if (lane.gate_open === 1'b1)   n_gate++;
        if (lane.entry_pulse === 1'b1 && lane.exit_pulse === 1'b1) n_both++;
        if (dut.r_state != IDLE)       n_busy++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic o, input logic i, input int n);
        lane.beam_outer = o;
        lane.beam_inner = i;
        repeat (n) @(negedge clk);
        $display("step outer=%0b inner=%0b space=%0b cycles=%0d state=%0d gate=%0b fault=%0b",
                 o, i, lane.space_avail, n, dut.r_state, lane.gate_open, lane.fault);
    endtask

    initial begin
        int e0, x0, g0, b0;

        lane.beam_outer  = 1'b0;
        lane.beam_inner  = 1'b0;
        lane.space_avail = 1'b1;
        reset_n          = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_entry", lane.entry_pulse, 1'b0);
        check("rst_exit",  lane.exit_pulse,  1'b0);
        check("rst_gate",  lane.gate_open,   1'b0);
        check("rst_fault", lane.fault,       1'b0);
        check("rst_state", dut.r_state,      IDLE);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Normal entry with space available
        e0 = n_entry; x0 = n_exit;
        hold(1'b1, 1'b0, 20);
        check("ent_s1_state", dut.r_state, ENT1);
        check("ent_s1_gate",  lane.gate_open, 1'b1);
        hold(1'b1, 1'b1, 20);
        check("ent_s2_state", dut.r_state, ENT2);
        check("ent_s2_gate",  lane.gate_open, 1'b1);
        hold(1'b0, 1'b1, 20);
        check("ent_s3_state", dut.r_state, ENT3);
        check("ent_s3_gate",  lane.gate_open, 1'b1);
        hold(1'b0, 1'b0, 20);
        check("ent_done_state", dut.r_state, IDLE);
        check("ent_done_gate",  lane.gate_open, 1'b0);
        check("ent_pulses",     n_entry - e0, 1);
        check("ent_no_exit",    n_exit - x0, 0);

        // Exit with lot full: barrier still raised for exiting vehicles
        lane.space_avail = 1'b0;
        e0 = n_entry; x0 = n_exit;
        hold(1'b0, 1'b1, 20);
        check("ext_s1_state", dut.r_state, EXT1);
        check("ext_s1_gate",  lane.gate_open, 1'b1);
        hold(1'b1, 1'b1, 20);
        check("ext_s2_gate",  lane.gate_open, 1'b1);
        hold(1'b1, 1'b0, 20);
        check("ext_s3_state", dut.r_state, EXT3);
        check("ext_s3_gate",  lane.gate_open, 1'b1);
        hold(1'b0, 1'b0, 20);
        check("ext_done_state", dut.r_state, IDLE);
        check("ext_pulses",     n_exit - x0, 1);
        check("ext_no_entry",   n_entry - e0, 0);

        // Back out of the outer beam: no pulse
        lane.space_avail = 1'b1;
        e0 = n_entry; x0 = n_exit;
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 20);
        check("backout_state",  dut.r_state, IDLE);
        check("backout_pulses", (n_entry - e0) + (n_exit - x0), 0);

        // Two-cycle glitch is shorter than the filter and must not leave IDLE
        b0 = n_busy;
        hold(1'b1, 1'b0, 2);
        hold(1'b0, 1'b0, 20);
        check("glitch_busy", n_busy - b0, 0);

        // Full lot at the break, space frees up mid-passage: gate stays down
        lane.space_avail = 1'b0;
        e0 = n_entry; g0 = n_gate;
        hold(1'b1, 1'b0, 20);
        lane.space_avail = 1'b1;
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 20);
        hold(1'b0, 1'b0, 20);
        check("full_gate_cycles", n_gate - g0, 0);
        check("full_entry",       n_entry - e0, 1);

        // Both beams at once from IDLE is illegal
        e0 = n_entry; x0 = n_exit;
        hold(1'b1, 1'b1, 20);
        check("both_fault", lane.fault, 1'b1);
        check("both_state", dut.r_state, WAIT_CLEAR);
        hold(1'b0, 1'b1, 20);
        check("both_half_clear_fault", lane.fault, 1'b1);
        hold(1'b0, 1'b0, 20);
        check("both_clear_fault", lane.fault, 1'b0);
        check("both_clear_state", dut.r_state, IDLE);
        check("both_pulses", (n_entry - e0) + (n_exit - x0), 0);

        // Outer beam stuck: timeout after ~1000 cycles in ENT1
        e0 = n_entry;
        hold(1'b1, 1'b0, 900);
        check("to_before_fault", lane.fault, 1'b0);
        check("to_before_state", dut.r_state, ENT1);
        hold(1'b1, 1'b0, 120);
        check("to_fault", lane.fault, 1'b1);
        check("to_state", dut.r_state, WAIT_CLEAR);
        check("to_gate",  lane.gate_open, 1'b0);
        hold(1'b0, 1'b0, 20);
        check("to_clear_fault", lane.fault, 1'b0);
        check("to_clear_state", dut.r_state, IDLE);
        check("to_no_entry",    n_entry - e0, 0);

        // Reset in the middle of ENT2 abandons the passage
        e0 = n_entry;
        hold(1'b1, 1'b0, 20);
        hold(1'b1, 1'b1, 10);
        check("mid_pre_state", dut.r_state, ENT2);
        check("mid_pre_gate",  lane.gate_open, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_gate",  lane.gate_open,   1'b0);
        check("mid_rst_fault", lane.fault,       1'b0);
        check("mid_rst_entry", lane.entry_pulse, 1'b0);
        check("mid_rst_state", dut.r_state,      IDLE);
        lane.beam_outer = 1'b0;
        lane.beam_inner = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        hold(1'b0, 1'b0, 20);
        check("mid_post_state", dut.r_state, IDLE);
        check("mid_no_entry",   n_entry - e0, 0);

        // Outer beam still broken across reset release starts a fresh entry
        lane.beam_outer = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        hold(1'b1, 1'b0, 20);
        check("fresh_state", dut.r_state, ENT1);
        hold(1'b0, 1'b0, 20);

        check("never_both_pulses", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
